// File: rtl/pipe_wb_pkg.sv
// Shared types for the MEM->WB write-back chain: stage bundle and clear helper.
// Field widths here are the widths the chain is built with (DATA_W/WBT_W match).
package pipe_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_WBT_W  = 4;

  localparam logic [4:0]          REG_ZERO = 5'd0;
  localparam logic [WB_WBT_W-1:0] WBT_NONE = '0;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 memread;
    logic [WB_WBT_W-1:0]  wbtype;
    logic [4:0]           rd;
    logic [WB_DATA_W-1:0] wbdata;
    logic [WB_DATA_W-1:0] memdata;
  } wb_stage_t;

  function automatic wb_stage_t wb_clear();
    wb_stage_t s;
    s        = '0;
    s.wbtype = WBT_NONE;
    s.rd     = REG_ZERO;
    return s;
  endfunction

endpackage

// File: rtl/pipe_wb_fwd_match.sv
// One forwarding query: finds the youngest valid writer of rd in the chain.
// Ports: rd (query reg), stages (all stage contents), hit, data (forwarded value).
module pipe_wb_fwd_match
  import pipe_wb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic [4:0]                 rd,
  input  wb_stage_t [DEPTH-1:0]      stages,
  output logic                       hit,
  output logic [WB_DATA_W-1:0]       data
);

  // Walk oldest to youngest so the lowest-index candidate overwrites last.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (stages[i].valid && stages[i].regwrite &&
          stages[i].rd == rd && rd != REG_ZERO) begin
        hit  = 1'b1;
        data = stages[i].memread ? stages[i].memdata
                                 : stages[i].wbdata;
      end
    end
  end

endmodule

// File: rtl/pipe_wb_chain.sv
// DEPTH-stage MEM->WB register chain with stall, masked flush, async reset
// and NQ forwarding query ports (built only when PIPE_WB_FWD_EN is defined).
// Ports: clk, rst, stall, flush, in_* (stage-0 input), out_* (last stage),
// stage_valid (per-stage valid), q_rd/q_hit/q_data (forwarding queries).
module pipe_wb_chain
  import pipe_wb_pkg::*;
#(
  parameter int               DATA_W     = WB_DATA_W,
  parameter int               WBT_W      = WB_WBT_W,
  parameter int               DEPTH      = 1,
  parameter logic [DEPTH-1:0] FLUSH_MASK = '1,
  parameter int               NQ         = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_regwrite,
  input  logic                 in_memread,
  input  logic [WBT_W-1:0]     in_wbtype,
  input  logic [4:0]           in_rd,
  input  logic [DATA_W-1:0]    in_wbdata,
  input  logic [DATA_W-1:0]    in_memdata,
  output logic                 out_valid,
  output logic                 out_regwrite,
  output logic                 out_memread,
  output logic [WBT_W-1:0]     out_wbtype,
  output logic [4:0]           out_rd,
  output logic [DATA_W-1:0]    out_wbdata,
  output logic [DATA_W-1:0]    out_memdata,
  output logic [DEPTH-1:0]     stage_valid,
  input  logic [NQ*5-1:0]      q_rd,
  output logic [NQ-1:0]        q_hit,
  output logic [NQ*DATA_W-1:0] q_data
);

  wb_stage_t [DEPTH-1:0] st;
  wb_stage_t             head;

  // A bubble enters as a fully cleared bundle.
  always_comb begin
    head = wb_clear();
    if (in_valid) begin
      head.valid    = 1'b1;
      head.regwrite = in_regwrite;
      head.memread  = in_memread;
      head.wbtype   = in_wbtype;
      head.rd       = in_rd;
      head.wbdata   = in_wbdata;
      head.memdata  = in_memdata;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    wb_stage_t nxt;
    wb_stage_t r;

    if (i == 0) begin : g_head
      assign nxt = head;
    end else begin : g_body
      assign nxt = st[i-1];
    end

    // Flush beats stall; unmasked stages ignore flush.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r <= wb_clear();
      end else if (flush && FLUSH_MASK[i]) begin
        r <= wb_clear();
      end else if (!stall) begin
        r <= nxt;
      end
    end

    assign st[i]          = r;
    assign stage_valid[i] = r.valid;
  end

  assign out_valid    = st[DEPTH-1].valid;
  assign out_regwrite = st[DEPTH-1].regwrite;
  assign out_memread  = st[DEPTH-1].memread;
  assign out_wbtype   = st[DEPTH-1].wbtype;
  assign out_rd       = st[DEPTH-1].rd;
  assign out_wbdata   = st[DEPTH-1].wbdata;
  assign out_memdata  = st[DEPTH-1].memdata;

`ifdef PIPE_WB_FWD_EN
  for (genvar k = 0; k < NQ; k++) begin : g_q
    pipe_wb_fwd_match #(
      .DEPTH(DEPTH)
    ) u_match (
      .rd    (q_rd[5*k +: 5]),
      .stages(st),
      .hit   (q_hit[k]),
      .data  (q_data[DATA_W*k +: DATA_W])
    );
  end
`else
  logic unused_q_rd;
  assign unused_q_rd = ^q_rd;
  assign q_hit       = '0;
  assign q_data      = '0;
`endif

endmodule

// File: tb/tb_pipe_wb_chain.sv
// Randomised bench for pipe_wb_chain (DEPTH=3, FLUSH_MASK=3'b011, NQ=2)
// against a record-array reference model plus directed scenarios.
module tb_pipe_wb_chain;

  localparam int DW = 32;
  localparam int WW = 4;
  localparam int D  = 3;
  localparam int NQ = 2;
  localparam logic [D-1:0] FM = 3'b011;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic in_valid, in_regwrite, in_memread;
  logic [WW-1:0] in_wbtype;
  logic [4:0] in_rd;
  logic [DW-1:0] in_wbdata, in_memdata;
  logic out_valid, out_regwrite, out_memread;
  logic [WW-1:0] out_wbtype;
  logic [4:0] out_rd;
  logic [DW-1:0] out_wbdata, out_memdata;
  logic [D-1:0] stage_valid;
  logic [NQ*5-1:0] q_rd;
  logic [NQ-1:0] q_hit;
  logic [NQ*DW-1:0] q_data;

  pipe_wb_chain #(
    .DATA_W(DW), .WBT_W(WW), .DEPTH(D),
    .FLUSH_MASK(FM), .NQ(NQ)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite),
    .in_memread(in_memread), .in_wbtype(in_wbtype),
    .in_rd(in_rd), .in_wbdata(in_wbdata),
    .in_memdata(in_memdata),
    .out_valid(out_valid), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_wbtype(out_wbtype),
    .out_rd(out_rd), .out_wbdata(out_wbdata),
    .out_memdata(out_memdata), .stage_valid(stage_valid),
    .q_rd(q_rd), .q_hit(q_hit), .q_data(q_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          rw;
    logic          mr;
    logic [WW-1:0] wt;
    logic [4:0]    rd;
    logic [DW-1:0] wd;
    logic [DW-1:0] md;
  } rec_t;

  rec_t m [D];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic model_q(input logic [4:0] r,
                         output logic h,
                         output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    for (int i = 0; i < D; i++) begin
      if (!h && m[i].v && m[i].rw && m[i].rd == r && r != 5'd0) begin
        h = 1'b1;
        d = m[i].mr ? m[i].md : m[i].wd;
      end
    end
  endtask

  task automatic check_all();
    rec_t o;
    logic [D-1:0] sv;
    logic h;
    logic [DW-1:0] d;
    o = m[D-1];
    for (int i = 0; i < D; i++) sv[i] = m[i].v;
    check("out_ctl",
          {52'd0, out_valid, out_regwrite, out_memread, out_wbtype, out_rd},
          {52'd0, o.v, o.rw, o.mr, o.wt, o.rd});
    check("out_wbdata", {32'd0, out_wbdata}, {32'd0, o.wd});
    check("out_memdata", {32'd0, out_memdata}, {32'd0, o.md});
    check("stage_valid", {61'd0, stage_valid}, {61'd0, sv});
    for (int k = 0; k < NQ; k++) begin
      model_q(q_rd[5*k +: 5], h, d);
`ifndef PIPE_WB_FWD_EN
      h = 1'b0;
      d = '0;
`endif
      check($sformatf("q_hit%0d", k), {63'd0, q_hit[k]}, {63'd0, h});
      check($sformatf("q_data%0d", k),
            {32'd0, q_data[DW*k +: DW]}, {32'd0, d});
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr,
                       input logic [WW-1:0] wt, input logic [4:0] rd,
                       input logic [DW-1:0] wd, input logic [DW-1:0] md);
    in_valid    = v;
    in_regwrite = rw;
    in_memread  = mr;
    in_wbtype   = wt;
    in_rd       = rd;
    in_wbdata   = wd;
    in_memdata  = md;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b1, 1'b1, 4'hF, 5'd7, 32'hFFFF_FFFF, 32'hEEEE_EEEE);
  endtask

  // One clock: check before the edge (inputs must not leak into
  // queries), advance the model, check after the edge.
  task automatic step(input logic s, input logic f);
    rec_t inp;
    rec_t old [D];
    stall = s;
    flush = f;
    inp = {in_valid, in_regwrite, in_memread, in_wbtype,
           in_rd, in_wbdata, in_memdata};
    #1 check_all();
    @(posedge clk);
    old = m;
    for (int i = 0; i < D; i++) begin
      if (f && FM[i]) m[i] = '0;
      else if (!s) begin
        if (i == 0) m[i] = inp.v ? inp : '0;
        else        m[i] = old[i-1];
      end
    end
    #1 check_all();
  endtask

  function automatic logic [4:0] pick_rd();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd7;
      3: return 5'd9;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    q_rd  = '0;
    bubble();
    for (int i = 0; i < D; i++) m[i] = '0;
    #12;
    check_all();
    check("rst_q_hit", {62'd0, q_hit}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Latency: three edges with no stall.
    drive(1'b1, 1'b1, 1'b0, 4'h2, 5'd5, 32'hA5A5_0001, 32'h0);
    step(0, 0);
    bubble();
    step(0, 0);
    check("lat_edge2", {63'd0, out_valid}, 64'd0);
    step(0, 0);
    check("lat_edge3", {27'd0, out_valid, out_rd, out_wbdata},
          {27'd0, 1'b1, 5'd5, 32'hA5A5_0001});

    // Two stalled cycles stretch latency to five edges.
    drive(1'b1, 1'b1, 1'b0, 4'h1, 5'd6, 32'h0000_0066, 32'h0);
    step(0, 0);
    bubble();
    step(0, 0);
    step(1, 0);
    step(1, 0);
    check("stall_edge4", {63'd0, out_valid}, 64'd0);
    step(0, 0);
    check("stall_edge5", {58'd0, out_valid, out_rd},
          {58'd0, 1'b1, 5'd6});

    // Full pipe, flush+stall: only the unmasked stage survives.
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'h3, 5'(10 + i), 32'(i + 1), 32'h0);
      step(0, 0);
    end
    bubble();
    step(1, 1);
    check("flush_sv", {61'd0, stage_valid}, {61'd0, 3'b100});
    check("flush_out", {27'd0, out_valid, out_rd, out_wbdata},
          {27'd0, 1'b1, 5'd10, 32'd1});

    // Two writers of x7: youngest (stage 0) wins.
    drive(1'b1, 1'b1, 1'b0, 4'h1, 5'd7, 32'h22, 32'h0);
    step(0, 0);
    bubble();
    step(0, 0);
    drive(1'b1, 1'b1, 1'b0, 4'h1, 5'd7, 32'h11, 32'h0);
    step(0, 0);
    q_rd = {5'd0, 5'd7};
    #1 check_all();
`ifdef PIPE_WB_FWD_EN
    check("fwd_young", {31'd0, q_hit, q_data[31:0]},
          {31'd0, 2'b01, 32'h11});
`else
    check("fwd_off", {30'd0, q_hit, q_data[31:0]}, 64'd0);
`endif

    // Load in stage 1 forwards memdata.
    drive(1'b1, 1'b1, 1'b1, 4'h4, 5'd9, 32'h4, 32'hDEAD_BEEF);
    step(0, 0);
    bubble();
    step(0, 0);
    q_rd = {5'd3, 5'd9};
    #1 check_all();
`ifdef PIPE_WB_FWD_EN
    check("fwd_load", {31'd0, q_hit, q_data[31:0]},
          {31'd0, 2'b01, 32'hDEAD_BEEF});
`else
    check("fwd_load_off", {30'd0, q_hit, q_data[31:0]}, 64'd0);
`endif

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom), 4'($urandom), pick_rd(),
            $urandom, $urandom);
      for (int k = 0; k < NQ; k++) q_rd[5*k +: 5] = pick_rd();
      step(1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 7) == 0));
    end

    // Async reset between edges with a full pipe.
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'h5, 5'd5, 32'(i + 5), 32'h0);
      step(0, 0);
    end
    q_rd = {5'd5, 5'd5};
    #2 rst = 1'b1;
    for (int i = 0; i < D; i++) m[i] = '0;
    #1 check_all();
    check("arst_out", {29'd0, out_valid, stage_valid, out_wbdata},
          64'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
